// File: rtl/gen_dncntr_timer.sv
// gen_dncntr_timer: loadable, retriggerable down-counter with expiry pulse and sticky flag.
// Optional GEN_DNCNTR_AUTORELOAD_EN: reload and keep running at expiry instead of stopping.
module gen_dncntr_timer #(
  parameter int MAX_LOAD = 52,
  localparam int W = ($clog2(MAX_LOAD + 1) < 1) ? 1 : $clog2(MAX_LOAD + 1)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [W-1:0] load_val_in,
  input  logic         start_in,
  input  logic         hold_in,
  input  logic         abort_in,
  output logic [W-1:0] count_out,
  output logic         busy_out,
  output logic         expired_out,
  output logic         expire_pls_out
);
  localparam logic [W-1:0] MAX_W = W'(MAX_LOAD);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t state;
  logic [W-1:0] load_clamped;
  assign load_clamped = (load_val_in > MAX_W) ? MAX_W : load_val_in;
`ifdef GEN_DNCNTR_AUTORELOAD_EN
  logic [W-1:0] reload_val;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) reload_val <= '0;
    else if (start_in && !abort_in) reload_val <= load_clamped;
`endif
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      count_out      <= '0;
      busy_out       <= 1'b0;
      expired_out    <= 1'b0;
      expire_pls_out <= 1'b0;
    end else begin
      expire_pls_out <= 1'b0;
      if (abort_in) begin
        state       <= IDLE;
        count_out   <= '0;
        busy_out    <= 1'b0;
        expired_out <= 1'b0;
      end else if (start_in) begin
        state       <= RUN;
        count_out   <= load_clamped;
        busy_out    <= 1'b1;
        expired_out <= 1'b0;
      end else if (state == RUN && !hold_in) begin
        if (count_out != '0) count_out <= count_out - 1'b1;
        else begin
          expire_pls_out <= 1'b1;
`ifdef GEN_DNCNTR_AUTORELOAD_EN
          count_out      <= reload_val;
`else
          state          <= EXPIRED;
          busy_out       <= 1'b0;
          expired_out    <= 1'b1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_gen_dncntr_timer.sv
// tb_gen_dncntr_timer: vector table, directed corner sequences and random stimulus vs a cycles-to-expiry model.
module tb_gen_dncntr_timer;
  localparam int MAX_LOAD = 52;
  localparam int W = 6;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [W-1:0] load_val_in = '0;
  logic start_in = 1'b0, hold_in = 1'b0, abort_in = 1'b0;
  logic [W-1:0] count_out;
  logic busy_out, expired_out, expire_pls_out;
  int n_cmp = 0, n_bad = 0;

  gen_dncntr_timer #(.MAX_LOAD(MAX_LOAD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .load_val_in(load_val_in), .start_in(start_in),
    .hold_in(hold_in), .abort_in(abort_in), .count_out(count_out), .busy_out(busy_out),
    .expired_out(expired_out), .expire_pls_out(expire_pls_out)
  );

  always #5 clk_in = ~clk_in;

  // Model: "left" is the number of un-held cycles until the expiry edge; count shown is left-1.
  int left = 0, reload_m = 0;
  bit run_m = 0, exp_m = 0, pls_m = 0;

  function automatic void model_reset();
    left = 0; reload_m = 0; run_m = 0; exp_m = 0; pls_m = 0;
  endfunction

  function automatic void model_step(input bit s, input int lv, input bit h, input bit a);
    int l;
    pls_m = 0;
    l = (lv > MAX_LOAD) ? MAX_LOAD : lv;
    if (a) begin
      run_m = 0; exp_m = 0; left = 0;
    end else if (s) begin
      reload_m = l; left = l + 1; run_m = 1; exp_m = 0;
    end else if (run_m && !h) begin
      left--;
      if (left == 0) begin
        pls_m = 1;
`ifdef GEN_DNCNTR_AUTORELOAD_EN
        left = reload_m + 1;
`else
        run_m = 0; exp_m = 1;
`endif
      end
    end
  endfunction

  function automatic logic [31:0] model_vec();
    logic [W-1:0] c;
    c = run_m ? W'(left - 1) : '0;
    return {23'd0, c, run_m, exp_m, pls_m};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {23'd0, count_out, busy_out, expired_out, expire_pls_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input bit s, input int lv, input bit h, input bit a, input string name);
    start_in = s; load_val_in = W'(lv); hold_in = h; abort_in = a;
    @(posedge clk_in);
    model_step(s, lv, h, a);
    #1;
    chk(name, dut_vec(), model_vec());
  endtask

  task automatic idle_n(input int n, input string name);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, name);
  endtask

  typedef struct {
    bit s; int lv; bit h; bit a;
    logic [W-1:0] c; logic b; logic e; logic p;
  } vec_t;
  vec_t tbl[$];

  initial begin
`ifdef GEN_DNCNTR_AUTORELOAD_EN
    tbl.push_back('{1, 2, 0, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 2, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 2, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
`else
    tbl.push_back('{1, 5, 0, 0, 5, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 4, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 3, 0, 0, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
`endif
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_state", dut_vec(), 32'd0);
    rst_in = 1'b0;
    idle_n(2, "idle_after_reset");
    chk("idle_hold_ignored", dut_vec(), 32'd0);

    foreach (tbl[i]) begin
      apply(tbl[i].s, tbl[i].lv, tbl[i].h, tbl[i].a, "table_model");
      chk($sformatf("table_row%0d", i), dut_vec(), {23'd0, tbl[i].c, tbl[i].b, tbl[i].e, tbl[i].p});
    end

    apply(1, 3, 0, 0, "hold_start");
    apply(0, 0, 0, 0, "hold_dec");
    apply(0, 0, 1, 0, "hold_1");
    chk("hold_frozen", {26'd0, count_out}, 32'd2);
    apply(0, 0, 1, 0, "hold_2");
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, "hold_run");
    chk("hold_delayed_pulse", {31'd0, expire_pls_out}, 32'd1);
    apply(0, 0, 0, 1, "abort_clr");

    apply(1, 0, 0, 0, "load0_start");
    chk("load0_no_early_pulse", {31'd0, expire_pls_out}, 32'd0);
    apply(0, 0, 0, 0, "load0_expire");
    chk("load0_pulse", {31'd0, expire_pls_out}, 32'd1);

    apply(1, MAX_LOAD + 10, 0, 0, "clamp_start");
    chk("clamp_value", {26'd0, count_out}, MAX_LOAD);

    apply(1, 4, 0, 0, "retrig_start");
    apply(0, 0, 0, 0, "retrig_k1");
    apply(1, 2, 0, 0, "retrig_k2");
    chk("retrig_count", {26'd0, count_out}, 32'd2);
    apply(0, 0, 0, 0, "retrig_k3");
    apply(0, 0, 0, 0, "retrig_k4");
    chk("retrig_no_early_pulse", {31'd0, expire_pls_out}, 32'd0);
    apply(0, 0, 0, 0, "retrig_k5");
    chk("retrig_pulse_k5", {31'd0, expire_pls_out}, 32'd1);

    apply(1, 1, 0, 0, "edge_retrig_start");
    apply(0, 0, 0, 0, "edge_retrig_zero");
    apply(1, 3, 0, 0, "edge_retrig_hit");
    chk("edge_retrig_nopulse", {26'd0, count_out, expire_pls_out}, {25'd0, 6'd3, 1'b0});

    apply(1, 4, 0, 0, "abort_start");
    apply(0, 0, 0, 0, "abort_k1");
    apply(0, 0, 0, 0, "abort_k2");
    apply(0, 0, 0, 1, "abort_k3");
    chk("abort_idle", dut_vec(), 32'd0);
    idle_n(6, "abort_no_pulse");
    apply(1, 0, 0, 0, "abort_start_pre");
    apply(1, 5, 0, 1, "abort_and_start");
    chk("abort_wins", dut_vec(), 32'd0);

    apply(1, 20, 0, 0, "arst_start");
    idle_n(3, "arst_run");
    #2 rst_in = 1'b1;
    #1 chk("async_reset_immediate", dut_vec(), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    apply(1, 2, 0, 0, "post_reset_start");
    idle_n(3, "post_reset_run");

    for (int i = 0; i < 3000; i++) begin
      bit s, h, a;
      int lv;
      s = ($urandom_range(0, 99) < 8);
      a = ($urandom_range(0, 99) < 3);
      h = ($urandom_range(0, 99) < 25);
      lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 8);
      apply(s, lv, h, a, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
